// File: rtl/draw_tank_sprite.sv
// draw_tank_sprite: composites a 48x64 ROM sprite over the incoming pixel stream
// with a fixed three-clock latency on every output.
// Ports:
//   clk, rst                        pixel clock, asynchronous active-high reset
//   hcount_in/vcount_in, *sync_in,
//   *blnk_in, rgb_in                upstream timing and background pixel
//   xpos, ypos                      requested sprite top-left, sampled at vsync rise
//   rom_addr / rom_rgb              sprite ROM address {y[5:0],x[5:0]} and its
//                                   data, which returns one clock later
//   hcount_out .. rgb_out           timing delayed by 3 clk, composited pixel
// Build option: define TRANSPARENT_KEY_EN to treat ROM colour 12'hF0F as transparent.
module draw_tank_sprite (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  localparam logic [11:0] SPRITE_W = 12'd48;
  localparam logic [11:0] SPRITE_H = 12'd64;
  localparam logic [11:0] KEY_RGB  = 12'hF0F;
  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } px_t;
  typedef struct packed {
    px_t  px;
    logic win;
  } stage_t;
  logic [10:0] x_lat_q, x_lat_d, y_lat_q, y_lat_d;
  logic        vsync_prev_q;
  logic [11:0] rom_addr_q, rom_addr_d;
  stage_t      s1_q, s1_d, s2_q;
  px_t         out_q, out_d;
  logic        win;
  logic [5:0]  dx, dy;
  logic        sprite_px;
  // Offsets only matter inside the window, where they are below 64, so
  // 6-bit modular subtraction gives the exact column/row.
  always_comb begin
    dx = hcount_in[5:0] - x_lat_q[5:0];
    dy = vcount_in[5:0] - y_lat_q[5:0];
    win = ({1'b0, hcount_in} >= {1'b0, x_lat_q}) && ({1'b0, hcount_in} < {1'b0, x_lat_q} + SPRITE_W) &&
          ({1'b0, vcount_in} >= {1'b0, y_lat_q}) && ({1'b0, vcount_in} < {1'b0, y_lat_q} + SPRITE_H);
    rom_addr_d = win ? {dy, dx} : 12'h000;
    x_lat_d = (vsync_in && !vsync_prev_q) ? xpos : x_lat_q;
    y_lat_d = (vsync_in && !vsync_prev_q) ? ypos : y_lat_q;
    s1_d.px = '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
    s1_d.win = win;
`ifdef TRANSPARENT_KEY_EN
    sprite_px = s2_q.win && (rom_rgb != KEY_RGB);
`else
    sprite_px = s2_q.win;
`endif
    out_d = s2_q.px;
    out_d.rgb = (s2_q.px.hb || s2_q.px.vb) ? 12'h000 : sprite_px ? rom_rgb : s2_q.px.rgb;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      vsync_prev_q <= 1'b0;
      rom_addr_q   <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      out_q        <= '0;
    end else begin
      x_lat_q      <= x_lat_d;
      y_lat_q      <= y_lat_d;
      vsync_prev_q <= vsync_in;
      rom_addr_q   <= rom_addr_d;
      s1_q         <= s1_d;
      s2_q         <= s1_q;
      out_q        <= out_d;
    end
  end
  assign rom_addr   = rom_addr_q;
  assign hcount_out = out_q.hc;
  assign vcount_out = out_q.vc;
  assign hsync_out  = out_q.hs;
  assign vsync_out  = out_q.vs;
  assign hblnk_out  = out_q.hb;
  assign vblnk_out  = out_q.vb;
  assign rgb_out    = out_q.rgb;
endmodule

// File: tb/tb_draw_tank_sprite.sv
// tb_draw_tank_sprite: table-driven and scoreboard checks for draw_tank_sprite
module tb_draw_tank_sprite;
  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } px_t;
  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [10:0] xp;
    logic [10:0] yp;
    logic [11:0] ea;
    logic [11:0] er;
  } vec_t;
`ifdef TRANSPARENT_KEY_EN
  localparam logic [11:0] KEYED = 12'h123;
  localparam bit KEY_ON = 1'b1;
`else
  localparam logic [11:0] KEYED = 12'hF0F;
  localparam bit KEY_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0, xpos = '0, ypos = '0;
  logic hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0, rom_rgb = '0, rom_addr, rgb_out;
  logic [10:0] hcount_out, vcount_out;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out;
  int checks = 0, failures = 0;
  logic [11:0] aq[$];
  px_t oq[$];
  logic [10:0] mx, my;
  logic mvp;
  vec_t tbl[$];
  draw_tank_sprite dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] rom_fn(input logic [11:0] a);
    return (a == 12'h000) ? 12'h0A0 : (a == 12'h001) ? 12'hF0F : a ^ 12'h5A5;
  endfunction
  always @(posedge clk) rom_rgb <= rom_fn(rom_addr);
  function automatic vec_t mk(input int hc, vc, hs, vs, hb, vb, rgb, xp, yp, ea, er);
    vec_t v;
    v.hc = 11'(hc); v.vc = 11'(vc); v.hs = 1'(hs); v.vs = 1'(vs); v.hb = 1'(hb); v.vb = 1'(vb);
    v.rgb = 12'(rgb); v.xp = 11'(xp); v.yp = 11'(yp); v.ea = 12'(ea); v.er = 12'(er);
    return v;
  endfunction
  task automatic prefill();
    aq.delete(); oq.delete();
    aq.push_back(12'h000);
    repeat (3) oq.push_back('0);
    mx = '0; my = '0; mvp = 1'b0;
  endtask
  task automatic step(input vec_t v);
    logic [11:0] ea;
    px_t eo, got;
    checks++;
    if (aq.size() == 0) begin
      failures++; $display("FAIL addr_queue_empty");
    end else begin
      ea = aq.pop_front();
      if (rom_addr !== ea) begin
        failures++; $display("FAIL rom_addr got=%h exp=%h", rom_addr, ea);
      end
    end
    checks++;
    got = '{hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
    if (oq.size() == 0) begin
      failures++; $display("FAIL out_queue_empty");
    end else begin
      eo = oq.pop_front();
      if (got !== eo) begin
        failures++;
        $display("FAIL pixel_out got hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h exp hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
                 got.hc, got.vc, got.hs, got.vs, got.hb, got.vb, got.rgb,
                 eo.hc, eo.vc, eo.hs, eo.vs, eo.hb, eo.vb, eo.rgb);
      end
    end
    hcount_in = v.hc; vcount_in = v.vc; hsync_in = v.hs; vsync_in = v.vs;
    hblnk_in = v.hb; vblnk_in = v.vb; rgb_in = v.rgb; xpos = v.xp; ypos = v.yp;
    aq.push_back(v.ea);
    oq.push_back('{v.hc, v.vc, v.hs, v.vs, v.hb, v.vb, v.er});
    if (v.vs && !mvp) begin mx = v.xp; my = v.yp; end
    mvp = v.vs;
    @(negedge clk);
  endtask
  task automatic mstep(input int hc, vc, hs, vs, hb, vb, rgb, xp, yp);
    logic w;
    logic [11:0] a, r, dx, dy;
    w = (hc >= int'(mx)) && (hc < int'(mx) + 48) && (vc >= int'(my)) && (vc < int'(my) + 64);
    dx = 12'(hc - int'(mx)); dy = 12'(vc - int'(my));
    a = w ? {dy[5:0], dx[5:0]} : 12'h000;
    r = rom_fn(a);
    step(mk(hc, vc, hs, vs, hb, vb, rgb, xp, yp, a,
            (hb != 0 || vb != 0) ? 0 : (w && !(KEY_ON && r == 12'hF0F)) ? int'(r) : rgb));
  endtask
  initial begin
    tbl.push_back(mk(1000, 600, 0, 0, 1, 1, 'h000, 100, 200, 'h000, 'h000));
    tbl.push_back(mk(1000, 600, 0, 1, 1, 1, 'h000, 100, 200, 'h000, 'h000));
    tbl.push_back(mk(100, 200, 0, 0, 0, 0, 'h123, 100, 200, 'h000, 'h0A0));
    tbl.push_back(mk(147, 263, 0, 0, 0, 0, 'h456, 100, 200, 'hFEF, 'hA4A));
    tbl.push_back(mk(148, 263, 0, 0, 0, 0, 'h789, 100, 200, 'h000, 'h789));
    tbl.push_back(mk(99, 200, 0, 0, 0, 0, 'h321, 100, 200, 'h000, 'h321));
    tbl.push_back(mk(101, 200, 0, 0, 0, 0, 'h123, 100, 200, 'h001, int'(KEYED)));
    tbl.push_back(mk(110, 210, 0, 0, 1, 0, 'hABC, 100, 200, 'h28A, 'h000));
    tbl.push_back(mk(110, 210, 1, 0, 0, 0, 'hABC, 100, 200, 'h28A, 'h72F));
    tbl.push_back(mk(120, 230, 0, 0, 0, 1, 'hDEF, 100, 200, 'h794, 'h000));
    tbl.push_back(mk(100, 200, 0, 0, 0, 0, 'h111, 300, 200, 'h000, 'h0A0));
    tbl.push_back(mk(300, 200, 0, 0, 0, 0, 'h555, 300, 200, 'h000, 'h555));
    tbl.push_back(mk(100, 200, 0, 1, 0, 0, 'h222, 300, 200, 'h000, 'h0A0));
    tbl.push_back(mk(305, 200, 0, 1, 0, 0, 'h333, 300, 200, 'h005, 'h5A0));
    tbl.push_back(mk(100, 200, 0, 0, 0, 0, 'h666, 300, 200, 'h000, 'h666));
    tbl.push_back(mk(305, 263, 0, 0, 0, 0, 'h444, 300, 200, 'hFC5, 'hA60));
    tbl.push_back(mk(305, 264, 0, 0, 0, 0, 'h777, 300, 200, 'h000, 'h777));
    tbl.push_back(mk(305, 199, 0, 0, 0, 0, 'h888, 300, 200, 'h000, 'h888));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prefill();
    foreach (tbl[i]) step(tbl[i]);
    mstep(1000, 600, 0, 0, 1, 1, 0, 780, 200);
    mstep(1000, 600, 0, 1, 1, 1, 0, 780, 200);
    mstep(1000, 600, 0, 0, 1, 1, 0, 780, 200);
    for (int h = 770; h < 800; h++) mstep(h, 205, 0, 0, 0, 0, 'hC00 | (h & 'hFF), 780, 200);
    for (int h = 0; h < 31; h++) mstep(h, 206, 0, 0, 0, 0, 'hB00 | h, 780, 200);
    for (int i = 0; i < 60; i++)
      mstep(int'($urandom_range(760, 850)), int'($urandom_range(190, 270)), int'($urandom_range(0, 1)), 0,
            int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 4095)), 780, 200);
    mstep(790, 210, 1, 0, 0, 0, 'h5A5, 780, 200);
    #2 rst = 1'b1;
    #1 checks++;
    if ({rom_addr, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== '0) begin
      failures++;
      $display("FAIL reset_clear got addr=%h hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h exp all zero",
               rom_addr, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out);
    end
    @(negedge clk);
    rst = 1'b0;
    prefill();
    step(mk(0, 0, 0, 0, 0, 0, 'h321, 500, 500, 'h000, 'h0A0));
    step(mk(1, 0, 0, 0, 0, 0, 'h123, 500, 500, 'h001, int'(KEYED)));
    step(mk(50, 0, 0, 0, 0, 0, 'h9AB, 500, 500, 'h000, 'h9AB));
    step(mk(47, 63, 0, 0, 0, 0, 'h135, 500, 500, 'hFEF, 'hA4A));
    repeat (3) step(mk(1000, 600, 0, 0, 1, 1, 0, 500, 500, 0, 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
